wbsdram_arbiter: RTL
====================

Name: wbsdram_arbiter

Overview:
Two-master Wishbone (pipelined) arbiter that shares the single SDRAM controller Wishbone port between a CPU-side master (A) and a DMA/debug-bus master (B). Sits in the ui_clk (o_sys_clk) domain directly in front of the SDRAM controller's Wishbone slave. Ownership is granted per bus cycle (cyc assertion) with round-robin priority. Outstanding requests are counted so acks and errors route only to the current owner.

Parameters:
AW, 26, Wishbone word address width (matches SDRAM slave AW for 32-bit DW)
DW, 32, Wishbone data width; SEL width is DW/8
LGOUT, 5, log2 of max outstanding requests; counter saturates at 2^LGOUT-1
LGTIMEOUT, 12, log2 of ack timeout in cycles (used only with WBARB_TIMEOUT_EN)

Ports:
i_clk  in  1  ui clock (SDRAM controller o_sys_clk)
i_rst  in  1  asynchronous active-high reset
i_a_cyc / i_b_cyc, i_a_stb / i_b_stb, i_a_we / i_b_we  in  1 each  master bus controls
i_a_addr / i_b_addr  in  AW  master word address
i_a_data / i_b_data  in  DW  master write data
i_a_sel / i_b_sel  in  DW/8  master byte select
o_a_ack / o_b_ack, o_a_stall / o_b_stall, o_a_err / o_b_err  out  1 each  master responses
o_a_data / o_b_data  out  DW  read data (both driven from i_data)
o_cyc, o_stb, o_we  out  1  slave bus controls
o_addr  out  AW;  o_data  out  DW;  o_sel  out  DW/8  slave request fields
i_ack, i_stall, i_err  in  1  slave responses
i_data  in  DW  slave read data
o_grant  out  2  one-hot current owner {B,A}, 00 when idle

Behaviour:
- States: IDLE, OWN_A, OWN_B. Registered. Reset -> IDLE, last_owner=B (so A wins first tie), outstanding=0.
- Reset outputs: o_cyc=o_stb=0, o_a_ack=o_b_ack=0, o_a_err=o_b_err=0, o_a_stall=o_b_stall=1, o_grant=00.
- IDLE: request = cyc&stb. Only one requester -> grant it. Both -> grant the one not equal to last_owner. Grant takes effect the next cycle. o_cyc=0 in IDLE.
- OWN_x: o_cyc=i_x_cyc; o_stb=i_x_stb & !full; o_we/o_addr/o_data/o_sel = owner's fields (combinational mux on state). o_x_stall = i_stall | full. Non-owner stall=1, ack=0, err=0.
- Outstanding counter: +1 on (o_stb & !i_stall); -1 on (i_ack | i_err); both in the same cycle -> unchanged. full = (count == 2^LGOUT-1). An ack/err with count 0 is ignored (not forwarded).
- o_x_ack = i_ack & owner==x & i_x_cyc & count!=0; o_x_err likewise with i_err. Same-cycle pass-through (zero latency).
- Owner drops cyc -> next state IDLE, last_owner=x, count cleared to 0 (Wishbone abort); late slave acks are discarded. IDLE lasts at least one cycle, so o_cyc is low for at least one cycle between owners.
- i_err: forwarded, decrements counter; ownership is unchanged until the owner drops cyc.
- Owner keeps the bus across any number of stb bursts while cyc is held. Fairness relies on masters dropping cyc.
- Async reset mid-transaction: all state is immediately forced to reset values, and o_cyc drops in the same cycle.

Optional Feature:
WBARB_TIMEOUT_EN: defined -> a LGTIMEOUT-bit counter runs while count!=0 and no ack/err arrives, and resets on any ack/err or on IDLE. On reaching all-ones: pulse o_x_err to the owner for one cycle, force o_cyc=0, clear count, go to IDLE. Undefined -> no counter; the arbiter waits indefinitely.

Test Plan:
- Reset released, A cyc+stb read addr 0x100 -> o_grant=01 next cycle, o_addr=0x100, slave ack 3 cycles later -> o_a_ack=1 with i_data, o_b_ack=0.
- A and B request in the same cycle from reset -> A granted. A drops cyc, both request again -> B granted after one IDLE cycle with o_cyc=0.
- A issues 4 pipelined writes, slave stalls 2 cycles -> count peaks at 4, four o_a_ack pulses, count returns to 0.
- LGOUT=2, A issues 5 requests with no acks -> o_stb low after 3 accepted, o_a_stall=1 until an ack arrives.
- A drops cyc with 2 outstanding, slave acks arrive afterwards -> no o_a_ack/o_b_ack, count=0, B granted.
- WBARB_TIMEOUT_EN, LGTIMEOUT=4, request never acked -> o_a_err pulses after 15 cycles, o_cyc=0, state IDLE.

Source files
------------

// File: rtl/wbsdram_arbiter.sv
// ---------------------------------------------------------------------------
// wbsdram_arbiter
// Two-master pipelined Wishbone arbiter in front of the SDRAM controller's
// Wishbone slave (ui_clk / o_sys_clk domain). Master A is the CPU side,
// master B the DMA/debug bus. The bus is granted per bus cycle (cyc held)
// with round-robin priority on ties. A count of outstanding requests makes
// sure acks and errors reach only the current owner. When the owner drops
// cyc, the count is cleared and any late slave acks are discarded.
//
// Optional feature: define WBARB_TIMEOUT_EN to add an ack timeout. When no
// ack or err arrives for 2^LGTIMEOUT-1 cycles while requests are
// outstanding, the owner receives a one-cycle err, o_cyc is dropped and the
// arbiter returns to IDLE. Without the macro the arbiter waits indefinitely.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_{a,b}_cyc/stb/we/addr/data/sel   master requests
//   o_{a,b}_ack/stall/err/data    master responses (data is i_data)
//   o_cyc/stb/we/addr/data/sel    slave request
//   i_ack/stall/err/data          slave response
//   o_grant                       one-hot owner {B,A}, 00 when idle
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no owner, o_cyc low, arbitrates pending cyc&stb
// S_OWN_A | master A owns the slave until it drops cyc
// S_OWN_B | master B owns the slave until it drops cyc
// ---------------------------------------------------------------------------
module wbsdram_arbiter #(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int LGOUT     = 5,
    parameter int LGTIMEOUT = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_cyc,
    input  logic              i_a_stb,
    input  logic              i_a_we,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [DW-1:0]     i_a_data,
    input  logic [DW/8-1:0]   i_a_sel,
    output logic              o_a_ack,
    output logic              o_a_stall,
    output logic              o_a_err,
    output logic [DW-1:0]     o_a_data,
    input  logic              i_b_cyc,
    input  logic              i_b_stb,
    input  logic              i_b_we,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [DW-1:0]     i_b_data,
    input  logic [DW/8-1:0]   i_b_sel,
    output logic              o_b_ack,
    output logic              o_b_stall,
    output logic              o_b_err,
    output logic [DW-1:0]     o_b_data,
    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_we,
    output logic [AW-1:0]     o_addr,
    output logic [DW-1:0]     o_data,
    output logic [DW/8-1:0]   o_sel,
    input  logic              i_ack,
    input  logic              i_stall,
    input  logic              i_err,
    input  logic [DW-1:0]     i_data,
    output logic [1:0]        o_grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
        S_OWN_B = 2'd2
    } state_t;

    localparam logic [LGOUT-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic             last_b, last_b_nxt;   // last owner was B
    logic [LGOUT-1:0] count, count_nxt;

    logic own_a, own_b, owned;
    logic owner_cyc, owner_stb;
    logic full, cnt_nz, tmo;
    logic req_a, req_b;
    logic inc, dec;

    assign own_a     = (state == S_OWN_A);
    assign own_b     = (state == S_OWN_B);
    assign owned     = own_a | own_b;
    assign owner_cyc = (own_a & i_a_cyc) | (own_b & i_b_cyc);
    assign owner_stb = (own_a & i_a_stb) | (own_b & i_b_stb);
    assign full      = (count == CNT_MAX);
    assign cnt_nz    = (count != '0);
    assign req_a     = i_a_cyc & i_a_stb;
    assign req_b     = i_b_cyc & i_b_stb;

`ifdef WBARB_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] timer;

    // An ack in the terminal cycle still counts as a normal response.
    assign tmo = owned && cnt_nz && !(i_ack || i_err) && (timer == '1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            timer <= '0;
        else if (!owned || !cnt_nz || i_ack || i_err || tmo)
            timer <= '0;
        else
            timer <= timer + LGTIMEOUT'(1);
    end
`else
    logic unused_lgtimeout;
    assign unused_lgtimeout = (LGTIMEOUT > 0);
    assign tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            last_b <= 1'b1;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            last_b <= last_b_nxt;
            count  <= count_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        last_b_nxt = last_b;
        case (state)
            S_IDLE: begin
                if (req_a && req_b)
                    state_nxt = last_b ? S_OWN_A : S_OWN_B;
                else if (req_a)
                    state_nxt = S_OWN_A;
                else if (req_b)
                    state_nxt = S_OWN_B;
            end
            S_OWN_A: begin
                if (!i_a_cyc || tmo) begin
                    state_nxt  = S_IDLE;
                    last_b_nxt = 1'b0;
                end
            end
            S_OWN_B: begin
                if (!i_b_cyc || tmo) begin
                    state_nxt  = S_IDLE;
                    last_b_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outstanding-request count; leaving ownership aborts the bus cycle,
    // so whatever is still in flight is forgotten.
    assign inc = o_stb & ~i_stall;
    assign dec = (i_ack | i_err) & cnt_nz;

    always_comb begin
        count_nxt = count;
        if (state == S_IDLE || state_nxt == S_IDLE)
            count_nxt = '0;
        else if (inc && !dec)
            count_nxt = count + LGOUT'(1);
        else if (dec && !inc)
            count_nxt = count - LGOUT'(1);
    end

    // Output logic
    always_comb begin
        o_cyc     = owner_cyc & ~tmo;
        o_stb     = owner_cyc & owner_stb & ~full & ~tmo;
        o_we      = own_b ? i_b_we   : i_a_we;
        o_addr    = own_b ? i_b_addr : i_a_addr;
        o_data    = own_b ? i_b_data : i_a_data;
        o_sel     = own_b ? i_b_sel  : i_a_sel;
        o_a_ack   = i_ack & own_a & i_a_cyc & cnt_nz;
        o_b_ack   = i_ack & own_b & i_b_cyc & cnt_nz;
        o_a_err   = own_a & ((i_err & i_a_cyc & cnt_nz) | tmo);
        o_b_err   = own_b & ((i_err & i_b_cyc & cnt_nz) | tmo);
        o_a_stall = own_a ? (i_stall | full) : 1'b1;
        o_b_stall = own_b ? (i_stall | full) : 1'b1;
        o_a_data  = i_data;
        o_b_data  = i_data;
        o_grant   = {own_b, own_a};
    end

endmodule
